// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default bus widths, fetch entry layout, PC step.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 32;
  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned PC_STEP    = 1;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage buses: instruction-memory request/response and the decode-side handshake.
interface if_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;

  // Fetch-unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  // Memory / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with push/pop/clear, head read-out and occupancy count.
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array, no reset needed since reads are qualified by count
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues word fetches from pc_in, tags responses, queues them for decode, drops stale responses after a redirect.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_write,
  input  logic              flush,
  if_fetch_unit_if.master   bus
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     qcount;
  logic [CW-1:0]     tag_count;
  logic [ADDR_W-1:0] tag_head;
  logic [EW-1:0]     q_head;
  logic [SW-1:0]     occupancy;
  logic              accept;
  logic              rsp;
  logic              live_rsp;
  logic              q_push;
  logic              q_pop;

  // Issue only when in-flight plus queued leaves room; uses registered counts only
  assign occupancy          = SW'(out_cnt) + SW'(qcount);
  assign bus.imem_req_valid = !rst && !flush && (occupancy < SW'(QDEPTH));
  assign bus.imem_req_addr  = pc_in;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;
  assign pc_write           = !rst && (accept || flush);

  // Responses are live only when no stale ones remain ahead of them
  assign rsp      = bus.imem_rsp_valid;
  assign live_rsp = rsp && (drop_cnt == '0);
  assign q_push   = live_rsp && !flush;
  assign q_pop    = bus.inst_valid && bus.inst_ready;

  assign bus.inst_valid = !rst && (qcount != '0);
  assign bus.inst_data  = bus.inst_valid ? q_head[DATA_W-1:0]  : '0;
  assign bus.inst_pc    = bus.inst_valid ? q_head[EW-1:DATA_W] : '0;

  // Outstanding-request and stale-response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(accept) - CW'(rsp);
      if (flush)
        drop_cnt <= out_cnt - CW'(rsp);
      else if (rsp && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
      assert (tag_count <= out_cnt);
    end
  end

  sync_fifo #(.WIDTH(ADDR_W), .DEPTH(QDEPTH)) u_tags (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (accept),
    .push_data (pc_in),
    .pop       (live_rsp),
    .head      (tag_head),
    .count     (tag_count)
  );

  sync_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (q_push),
    .push_data ({tag_head, bus.imem_rsp_data}),
    .pop       (q_pop),
    .head      (q_head),
    .count     (qcount)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: epoch-based reference model, memory model with configurable latency, directed scenarios.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc_in;
  logic        pc_write;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.ADDR_W(CPU_ADDR_W), .DATA_W(CPU_DATA_W), .QDEPTH(QD)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .pc_write (pc_write),
    .flush    (flush),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t mq[$];
  fetch_entry_t seen[$];

  int          cyc, epoch, lat, n_checks, n_fail, n_acc, n_pcw;
  logic [31:0] pc_reg, rst_pc, s_target;
  logic        s_rst, s_flush, s_req_ready, s_inst_ready;

  function automatic logic [31:0] memfn(logic [31:0] a);
    return 32'h1300_0000 | a;
  endfunction

  function automatic int dead_cnt();
    int n = 0;
    foreach (memq[i]) if (memq[i].ep != epoch) n++;
    return n;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, compare after settling, advance model for the coming edge
  task automatic tick();
    logic         rsp, exp_rv, exp_acc, exp_iv, exp_pcw;
    fetch_entry_t head;
    mreq_t        m;
    int           due;
    rst                = s_rst;
    flush              = s_flush;
    bus.imem_req_ready = s_req_ready;
    bus.inst_ready     = s_inst_ready;
    pc_in              = pc_reg;
    rsp                = !s_rst && (memq.size() > 0) && (memq[0].due == cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? memfn(memq[0].addr) : 32'h0;
    #1;
    exp_rv  = !s_rst && !s_flush && ((memq.size() + mq.size()) < QD);
    exp_acc = exp_rv && s_req_ready;
    exp_pcw = !s_rst && (exp_acc || s_flush);
    exp_iv  = !s_rst && (mq.size() > 0);
    head    = exp_iv ? mq[0] : '0;
    chk("req_valid",  64'(bus.imem_req_valid), 64'(exp_rv));
    chk("req_addr",   64'(bus.imem_req_addr),  64'(pc_reg));
    chk("pc_write",   64'(pc_write),           64'(exp_pcw));
    chk("inst_valid", 64'(bus.inst_valid),     64'(exp_iv));
    chk("inst_pc",    64'(bus.inst_pc),        64'(head.pc));
    chk("inst_data",  64'(bus.inst_data),      64'(head.inst));
    if (!s_rst) begin
      chk("out_cnt",  64'(dut.out_cnt),  64'(memq.size()));
      chk("drop_cnt", 64'(dut.drop_cnt), 64'(dead_cnt()));
      chk("q_bound",  64'(dut.qcount <= QD), 64'(1));
    end
    if (exp_acc) n_acc++;
    if (exp_pcw) n_pcw++;
    if (s_rst) begin
      memq.delete();
      mq.delete();
      pc_reg = rst_pc;
    end else begin
      if (exp_iv && s_inst_ready) seen.push_back(mq.pop_front());
      if (rsp) begin
        m = memq.pop_front();
        if (!s_flush && m.ep == epoch) mq.push_back('{pc: m.addr, inst: memfn(m.addr)});
      end
      if (s_flush) begin
        mq.delete();
        epoch++;
        pc_reg = s_target;
      end else if (exp_acc) begin
        due = cyc + lat;
        if (memq.size() > 0 && memq[memq.size()-1].due >= due) due = memq[memq.size()-1].due + 1;
        memq.push_back('{addr: pc_reg, due: due, ep: epoch});
        pc_reg = pc_reg + PC_STEP;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(logic [31:0] start_pc, int latency);
    rst_pc  = start_pc;
    lat     = latency;
    s_rst   = 1'b1;
    s_flush = 1'b0;
    run(2);
    s_rst = 1'b0;
    seen.delete();
    n_acc = 0;
    n_pcw = 0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1;
    pc_reg = 0; rst_pc = 0; s_target = 0;
    s_rst = 1'b1; s_flush = 1'b0; s_req_ready = 1'b1; s_inst_ready = 1'b1;
    rst = 1'b1; flush = 1'b0; pc_in = 0;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 0;
    @(negedge clk);

    // Streaming with 1-cycle memory
    do_reset(32'h0, 1);
    run(12);
    chk("t1_rate", 64'(seen.size() >= 6), 64'(1));
    chk("t1_pc0",  64'(seen[0].pc), 64'h0);
    chk("t1_d0",   64'(seen[0].inst), 64'h1300_0000);
    chk("t1_pc1",  64'(seen[1].pc), 64'h1);
    chk("t1_d2",   64'(seen[2].inst), 64'h1300_0002);

    // Decode stalled: two requests, then hold
    do_reset(32'h0, 1);
    s_inst_ready = 1'b0;
    run(10);
    chk("t2_acc",   64'(n_acc), 64'd2);
    chk("t2_pc",    64'(pc_reg), 64'd2);
    chk("t2_qsize", 64'(mq.size()), 64'd2);
    chk("t2_dutq",  64'(dut.qcount), 64'd2);
    s_inst_ready = 1'b1;
    run(6);
    chk("t2_pc0", 64'(seen[0].pc), 64'h0);
    chk("t2_pc1", 64'(seen[1].pc), 64'h1);

    // Memory not ready for 5 cycles, then a single accept
    do_reset(32'h0, 1);
    s_req_ready = 1'b0;
    run(5);
    chk("t3_noacc", 64'(n_acc), 64'd0);
    chk("t3_hold",  64'(pc_reg), 64'd0);
    s_req_ready = 1'b1;
    run(1);
    s_req_ready = 1'b0;
    run(3);
    chk("t3_acc", 64'(n_acc), 64'd1);
    chk("t3_pcw", 64'(n_pcw), 64'd1);
    s_req_ready = 1'b1;

    // Redirect with pc 4,5 in flight
    do_reset(32'h4, 5);
    run(2);
    s_flush = 1'b1; s_target = 32'h40;
    run(1);
    s_flush = 1'b0;
    chk("t4_drop", 64'(dut.drop_cnt), 64'd2);
    run(14);
    chk("t4_pc",   64'(seen[0].pc), 64'h40);
    chk("t4_data", 64'(seen[0].inst), 64'h1300_0040);

    // Redirect coincident with a response and a pop
    do_reset(32'h0, 1);
    run(2);
    s_flush = 1'b1; s_target = 32'h80;
    run(1);
    s_flush = 1'b0;
    chk("t5_popped", 64'(seen.size()), 64'd1);
    chk("t5_pc0",    64'(seen[0].pc), 64'h0);
    chk("t5_drop",   64'(dut.drop_cnt), 64'd0);
    chk("t5_out",    64'(dut.out_cnt), 64'd0);
    run(8);
    chk("t5_next", 64'(seen[1].pc), 64'h80);

    // Back-to-back redirects
    do_reset(32'h10, 4);
    run(2);
    s_flush = 1'b1; s_target = 32'h100;
    run(1);
    s_target = 32'h200;
    run(1);
    s_flush = 1'b0;
    run(14);
    chk("t6_pc", 64'(seen[0].pc), 64'h200);

    // Reset mid-operation
    do_reset(32'h0, 3);
    s_inst_ready = 1'b0;
    run(6);
    s_rst = 1'b1;
    run(1);
    s_rst = 1'b0;
    chk("t7_valid", 64'(bus.inst_valid), 64'd0);
    chk("t7_out",   64'(dut.out_cnt), 64'd0);
    chk("t7_drop",  64'(dut.drop_cnt), 64'd0);
    chk("t7_q",     64'(dut.qcount), 64'd0);
    s_inst_ready = 1'b1;
    run(1);
    chk("t7_addr", 64'(memq[0].addr), 64'h0);
    run(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
